// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-FF synchronizer and mid-bit sampling.
// Optional 2-of-3 majority sampling when UART_RX_MAJORITY_EN is defined.
module uart_rx #(
    parameter int CLK_PARAM = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA_OUT,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int BAUD_CLK = CLK_PARAM / BAUD_RATE;
    localparam int HALF     = BAUD_CLK / 2;
    localparam int CW       = $clog2(BAUD_CLK);

    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nx;
    logic [7:0]      shift;
    logic [7:0]      shift_nx;
    logic            smp;
    logic            at_half;
    logic            at_full;
    logic            valid_nx;
    logic            ferr_nx;
    logic            busy_nx;

    assign at_half = (cnt == CW'(HALF - 1));
    assign at_full = (cnt == CW'(BAUD_CLK - 1));

    // Two metastability flops, then a retiming flop that produces rx_s.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= 2'b11;
            rx_s <= 1'b1;
        end else begin
            sync <= {sync[0], RX};
            rx_s <= sync[1];
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // Keep the two previous rx_s values for the 2-of-3 vote.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign smp = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) |
                 (rx_hist[0] & rx_hist[1]);
`else
    assign smp = rx_s;
`endif

    // State, counter, bit index and shift register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_BREAK;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    // Next-state logic: start validation, data capture, stop check.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        unique case (state)
            S_BREAK: begin
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            S_START: begin
                cnt_nx = cnt + CW'(1);
                if (at_half) begin
                    cnt_nx     = '0;
                    bit_idx_nx = 3'd0;
                    state_nx   = smp ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_nx = cnt + CW'(1);
                if (at_full) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = smp;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_nx = cnt + CW'(1);
                if (at_full) begin
                    cnt_nx   = '0;
                    state_nx = smp ? S_IDLE : S_BREAK;
                end
            end
            default: begin
                state_nx = S_BREAK;
            end
        endcase
    end

    // Output decode; registered below so outputs are glitch-free.
    always_comb begin
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        busy_nx  = (state_nx != S_IDLE);
        if (state == S_STOP && at_full) begin
            valid_nx = smp;
            ferr_nx  = !smp;
        end
    end

    // Output registers; DATA_OUT only moves on a good frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_OUT  <= 8'h00;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            VALID     <= valid_nx;
            FRAME_ERR <= ferr_nx;
            BUSY      <= busy_nx;
            if (valid_nx) begin
                DATA_OUT <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: per-cycle comparison of uart_rx against a frame-level model.
// Line waveform is prebuilt; the model parses it with the UART framing rules.
module tb_uart_rx;

    localparam int CLKP  = 160;
    localparam int BAUD  = 10;
    localparam int B     = CLKP / BAUD;
    localparam int HALF  = B / 2;
    localparam int N     = 6000;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] MAJ_EXP = 8'h00;
`else
    localparam logic [7:0] MAJ_EXP = 8'h08;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    bit         wave  [N];
    bit         rstw  [N];
    bit         exp_v [N];
    bit         exp_f [N];
    bit         exp_b [N];
    logic [7:0] ev_d  [N];
    logic [7:0] exp_d [N];

    int checks   = 0;
    int failures = 0;
    int cur      = 0;
    int a5_ev;
    int maj_ev;

    uart_rx #(
        .CLK_PARAM(CLKP),
        .BAUD_RATE(BAUD)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .RX       (rx),
        .DATA_OUT (data_out),
        .VALID    (valid),
        .FRAME_ERR(frame_err),
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    task automatic set_lvl(input int t, input int n, input bit v);
        for (int k = 0; k < n; k++)
            if (t + k < N) wave[t + k] = v;
    endtask

    task automatic put_frame(input int t, input logic [7:0] d,
                             input bit stop);
        set_lvl(t, B, 1'b0);
        for (int n = 0; n < 8; n++)
            set_lvl(t + (n + 1) * B, B, d[n]);
        set_lvl(t + 9 * B, B, stop);
    endtask

    // Line level as seen by the receiver's decision logic, index = RX edge.
    function automatic bit samp(input int i, input int r);
        if (i >= r - 4 && i <= r) return 1'b1;
        if (i < 0 || i >= N) return 1'b1;
        return wave[i];
    endfunction

    function automatic bit dec(input int i, input int r);
`ifdef UART_RX_MAJORITY_EN
        bit a, b, c;
        a = samp(i, r);
        b = samp(i - 1, r);
        c = samp(i - 2, r);
        return (a & b) | (a & c) | (b & c);
`else
        return samp(i, r);
`endif
    endfunction

    task automatic mark(input int a, input int b, input int r, input int l);
        for (int e = a; e <= b; e++)
            if (e > r && e < l && e < N) exp_b[e] = 1'b1;
    endtask

    // Parse frames between reset edge r and next reset edge l.
    task automatic run_segment(input int r, input int l);
        int p, j, bb, s, bfrom;
        bit brk;
        logic [7:0] byt;
        p     = r - 2;
        brk   = 1'b1;
        bfrom = r + 1;
        while (p < l) begin
            if (brk) begin
                bb = p;
                while (samp(bb, r) == 1'b0) bb++;
                mark(bfrom, bb + 2, r, l);
                p   = bb + 1;
                brk = 1'b0;
            end else begin
                j = p;
                while (j < l && samp(j, r) == 1'b1) j++;
                if (j + 3 >= l) break;
                if (dec(j + HALF, r)) begin
                    mark(j + 3, j + HALF + 2, r, l);
                    p = j + HALF + 1;
                end else begin
                    for (int n = 0; n < 8; n++)
                        byt[n] = dec(j + HALF + (n + 1) * B, r);
                    s = j + HALF + 9 * B;
                    mark(j + 3, s + 2, r, l);
                    if (s + 3 >= l) break;
                    if (dec(s, r)) begin
                        exp_v[s + 3] = 1'b1;
                        ev_d[s + 3]  = byt;
                        p = s + 1;
                    end else begin
                        exp_f[s + 3] = 1'b1;
                        p     = s + 1;
                        brk   = 1'b1;
                        bfrom = s + 3;
                    end
                end
            end
        end
    endtask

    task automatic build_model();
        int l;
        logic [7:0] d;
        for (int k = 0; k < N; k++) begin
            exp_v[k] = 1'b0;
            exp_f[k] = 1'b0;
            exp_b[k] = 1'b0;
            ev_d[k]  = 8'h00;
        end
        for (int r = 0; r < N; r++) begin
            if (rstw[r] && (r + 1 >= N || !rstw[r + 1])) begin
                l = N;
                for (int k = N - 1; k > r; k--)
                    if (rstw[k]) l = k;
                run_segment(r, l);
            end
        end
        d = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (rstw[k]) d = 8'h00;
            else if (exp_v[k]) d = ev_d[k];
            exp_d[k] = d;
        end
    endtask

    initial begin
        int t, gap, gl, hold;
        logic [7:0] by;
        bit stp;
        for (int k = 0; k < N; k++) begin
            wave[k] = 1'b1;
            rstw[k] = (k <= 3);
        end
        put_frame(20, 8'hA5, 1'b1);
        a5_ev = 20 + 3 + HALF + 9 * B;
        put_frame(200, 8'h00, 1'b1);
        put_frame(200 + 10 * B, 8'hFF, 1'b1);
        put_frame(200 + 20 * B, 8'h3C, 1'b1);
        put_frame(700, 8'h5A, 1'b0);
        set_lvl(700 + 10 * B, 3 * B, 1'b0);
        put_frame(960, 8'h81, 1'b1);
        set_lvl(1140, 3, 1'b0);
        put_frame(1200, 8'hC3, 1'b1);
        rstw[1200 + 5 * B + HALF] = 1'b1;
        set_lvl(1200 + 5 * B + HALF + 1, 100, 1'b1);
        put_frame(1400, 8'h7E, 1'b1);
        put_frame(1600, 8'h00, 1'b1);
        wave[1600 + HALF + 4 * B] = 1'b1;
        maj_ev = 1600 + 3 + HALF + 9 * B;
        t = 1800;
        while (t + 14 * B + 40 < N) begin
            gap = $urandom_range(0, 24);
            if (gap >= 6 && $urandom_range(0, 3) == 0) begin
                gl = $urandom_range(1, 5);
                set_lvl(t + 1, gl, 1'b0);
            end
            t   = t + gap;
            by  = 8'($urandom);
            stp = ($urandom_range(0, 5) != 0);
            put_frame(t, by, stp);
            t = t + 10 * B;
            if (!stp) begin
                hold = $urandom_range(0, 2 * B);
                set_lvl(t, hold, 1'b0);
                t = t + hold;
            end
        end
        build_model();

        rst = rstw[0];
        rx  = wave[0];
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            @(negedge clk);
            cur = i;
            chk("valid", valid, exp_v[i]);
            chk("frame_err", frame_err, exp_f[i]);
            chk("busy", busy, exp_b[i]);
            chk("data_out", data_out, exp_d[i]);
            if (i == a5_ev) begin
                chk("a5_valid", valid, 1);
                chk("a5_data", data_out, 8'hA5);
            end
            if (i == maj_ev) begin
                chk("maj_valid", valid, 1);
                chk("maj_data", data_out, MAJ_EXP);
            end
            if (i + 1 < N) begin
                rx  = wave[i + 1];
                rst = rstw[i + 1];
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed baud rate derived from the system clock. It is the receive-side counterpart of the team's UART transmitter. It synchronizes the asynchronous RX line, detects and validates the start bit, samples each bit at mid-bit, and presents each completed byte with a one-cycle strobe. Framing errors are flagged.

## Interface
- CLK_PARAM, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits/s.
- Derived locals:
  - BAUD_CLK = CLK_PARAM / BAUD_RATE, integer division; 5208 at defaults.
  - HALF = BAUD_CLK / 2; 2604 at defaults.
  - BAUD_CLK ≥ 4 required.
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- RX  input  1  asynchronous serial line; idle high.
- DATA_OUT  output  8  last correctly framed byte; held until the next good frame.
- VALID  output  1  one-cycle pulse when DATA_OUT is updated.
- FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
- BUSY  output  1  high whenever state ≠ IDLE.

## Operation
- **Synchronizer.** RX passes through a 2-FF synchronizer (both FFs reset to 1). The output is rx_s. All decisions use rx_s only.
- **Counter.** cnt is a $clog2(BAUD_CLK)-bit cycle counter. bit_idx is a 3-bit data index. A shift register fills LSB first.
- **States:**
  - BREAK: wait for rx_s = 1, then go to IDLE. BREAK is the reset state, so a line stuck low never produces a frame.
  - IDLE: on rx_s = 0, go to START with cnt = 0.
  - START: increment cnt. At the edge where cnt = HALF−1, take the sample. If the sample is 0, go to DATA with cnt = 0 and bit_idx = 0. If it is 1 (glitch), go to IDLE with no output.
  - DATA: increment cnt. At cnt = BAUD_CLK−1, sample into shift[bit_idx] and reset cnt to 0. After bit_idx = 7, go to STOP; otherwise increment bit_idx.
  - STOP: at cnt = BAUD_CLK−1, take the sample.
    - Sample = 1: load DATA_OUT, pulse VALID, go to IDLE.
    - Sample = 0: pulse FRAME_ERR, leave DATA_OUT unchanged, go to BREAK.
- **Reset.** RST has priority in every state, including mid-frame. The partial byte is discarded.
- **Reset values:**
  - DATA_OUT = 8'h00, VALID = 0, FRAME_ERR = 0, BUSY = 0.
  - state = BREAK, cnt = 0, bit_idx = 0, synchronizer = 2'b11.
  - BUSY is 1 in BREAK. It is a registered decode, so it reads 0 on the reset cycle and follows state afterwards.
- **Exclusivity.** VALID and FRAME_ERR never assert in the same cycle.

## Timing
- Let E0 be the first CLK edge that registers RX low.
- rx_s goes low after E2. START is entered at E3.
- Decision edges:
  - start-bit check at E(3+HALF);
  - data bit n at E(3+HALF+(n+1)·BAUD_CLK);
  - stop bit at E(3+HALF+9·BAUD_CLK).
- VALID/FRAME_ERR are high for the single cycle following the stop decision edge. At defaults this is edge E49479.
- Back-to-back frames: IDLE is reached at the stop decision, roughly half a bit before the frame ends. A new start edge arriving immediately after the stop bit is accepted with no lost cycles.
- The start glitch filter rejects low pulses shorter than about HALF cycles.
- Tolerated baud mismatch: about ±4% accumulated over 9.5 bits.

## Configuration
- **UART_RX_MAJORITY_EN defined:** each sampled value (start, data, stop) is the 2-of-3 majority of rx_s at the decision edge and the two preceding edges. Decision edges and latency are unchanged.
- **UART_RX_MAJORITY_EN undefined:** each sample is the single rx_s value at the decision edge.

## Test plan
- **Good frame.** Send 0xA5 at exactly BAUD_CLK cycles per bit. Expect VALID for one cycle at E49479, DATA_OUT = 0xA5, BUSY low after, FRAME_ERR never asserted.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x3C with no idle gap. Expect three VALID pulses 10·BAUD_CLK apart, with DATA_OUT 0x00, 0xFF, 0x3C in turn.
- **Framing error.** Send 0x5A with the stop bit low, and hold RX low 3·BAUD_CLK more. Expect one FRAME_ERR pulse, DATA_OUT unchanged, no VALID, state BREAK until RX returns high. A following good 0x81 is then received correctly.
- **Start glitch.** Drive RX low for 1000 cycles, then high. Expect no VALID and no FRAME_ERR; BUSY drops after the start check at E(3+HALF).
- **Reset mid-frame.** Assert RST for one cycle during bit 4 of a 0xC3 frame, with RX held high until the next frame. Expect no VALID for the aborted frame and all outputs at reset values; a following 0x7E frame is received correctly.
- **Majority (macro defined).** Inject a one-cycle high pulse on RX, aligned so rx_s is high exactly at the bit-3 decision edge of a 0x00 frame. Expect DATA_OUT = 0x00 with the macro defined, and 0x08 with it undefined.
